// File: rtl/ex_stage_m_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_m_pkg
// Description : Opcode, funct and multiply-FSM encodings for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_stage_m_pkg;

    localparam logic [6:0] C_INST_TYPE_I     = 7'b0010011;
    localparam logic [6:0] C_INST_TYPE_R_M   = 7'b0110011;
    localparam logic [6:0] C_INST_TYPE_B     = 7'b1100011;
    localparam logic [6:0] C_INST_TYPE_LUI   = 7'b0110111;
    localparam logic [6:0] C_INST_TYPE_AUIPC = 7'b0010111;
    localparam logic [6:0] C_INST_TYPE_JAL   = 7'b1101111;
    localparam logic [6:0] C_INST_TYPE_JALR  = 7'b1100111;

    localparam logic [2:0] C_F3_ADD_SUB = 3'b000;
    localparam logic [2:0] C_F3_SLL     = 3'b001;
    localparam logic [2:0] C_F3_SLT     = 3'b010;
    localparam logic [2:0] C_F3_SLTU    = 3'b011;
    localparam logic [2:0] C_F3_XOR     = 3'b100;
    localparam logic [2:0] C_F3_SR      = 3'b101;
    localparam logic [2:0] C_F3_OR      = 3'b110;
    localparam logic [2:0] C_F3_AND     = 3'b111;

    localparam logic [2:0] C_F3_BEQ  = 3'b000;
    localparam logic [2:0] C_F3_BNE  = 3'b001;
    localparam logic [2:0] C_F3_BLT  = 3'b100;
    localparam logic [2:0] C_F3_BGE  = 3'b101;
    localparam logic [2:0] C_F3_BLTU = 3'b110;
    localparam logic [2:0] C_F3_BGEU = 3'b111;

    localparam logic [2:0] C_F3_JALR = 3'b000;

    localparam logic [2:0] C_F3_MUL    = 3'b000;
    localparam logic [2:0] C_F3_MULH   = 3'b001;
    localparam logic [2:0] C_F3_MULHSU = 3'b010;

    localparam logic [6:0] C_FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] C_FUNCT7_ALT  = 7'b0100000;
    localparam logic [6:0] C_FUNCT7_M    = 7'b0000001;

    localparam logic [1:0] C_MUL_IDLE = 2'd0;
    localparam logic [1:0] C_MUL_BUSY = 2'd1;
    localparam logic [1:0] C_MUL_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = C_MUL_IDLE,
        S_BUSY = C_MUL_BUSY,
        S_DONE = C_MUL_DONE
    } mul_state_t;

endpackage
`default_nettype wire

// File: rtl/ex_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : ex_mul_iter
// Description : Iterative sign-magnitude shift-add multiplier, one bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*XLEN-1:0] product
);
    import ex_stage_m_pkg::*;

    localparam int C_CW = $clog2(XLEN);

    mul_state_t        r_state;
    mul_state_t        w_state_nxt;
    logic [C_CW-1:0]   r_cnt;
    logic [2*XLEN-1:0] r_acc;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic              r_neg;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_last;

    // Magnitudes are treated as unsigned, so |-2^(XLEN-1)| needs no extra bit.
    assign w_a_neg = sign_a & a[XLEN-1];
    assign w_b_neg = sign_b & b[XLEN-1];
    assign w_a_mag = w_a_neg ? ('0 - a) : a;
    assign w_b_mag = w_b_neg ? ('0 - b) : b;
    assign w_last  = (r_cnt == C_CW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_a_neg ^ w_b_neg;
                    end
                end
                S_BUSY: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (!w_last) r_cnt <= r_cnt + C_CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy    = (r_state == S_BUSY);
    assign done    = (r_state == S_DONE);
    assign product = r_neg ? ('0 - r_acc) : r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage_m.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage_m
// Description : Execute stage: RV32I ALU, branches, jumps, LUI/AUIPC, iterative RV32M multiply.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage_m #(
    parameter int XLEN   = 32,
    parameter int MUL_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] inst_addr_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_wen_i,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_wen_o,
    output logic [XLEN-1:0] jump_addr_o,
    output logic            jump_en_o,
    output logic            hold_flag_o
);
    import ex_stage_m_pkg::*;

    localparam int C_SHW = $clog2(XLEN);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic [C_SHW-1:0]  w_shamt;
    logic [XLEN-1:0]   w_imm_b;
    logic [XLEN-1:0]   w_imm_j;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_sum;
    logic [XLEN-1:0]   w_pc_plus4;
    logic              w_lt_s;
    logic              w_lt_u;
    logic              w_sub;
    logic              w_i_ok;
    logic              w_r_ok;
    logic              w_taken;
    logic [XLEN-1:0]   w_alu_res;

    logic              w_is_mul;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic              w_mul_sign_a;
    logic              w_mul_sign_b;
    logic [2*XLEN-1:0] w_product;

    logic [XLEN-1:0]   w_rd_data;
    logic              w_writes;
    logic              w_jump_en;
    logic [XLEN-1:0]   w_jump_addr;
    logic              w_hold;

    assign w_opcode   = inst_i[6:0];
    assign w_funct3   = inst_i[14:12];
    assign w_funct7   = inst_i[31:25];
    assign w_shamt    = op2_i[C_SHW-1:0];
    assign w_imm_b    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign w_imm_j    = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign w_imm_u    = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign w_sum      = op1_i + op2_i;
    assign w_pc_plus4 = inst_addr_i + XLEN'(4);
    assign w_lt_s     = ($signed(op1_i) < $signed(op2_i));
    assign w_lt_u     = (op1_i < op2_i);
    assign w_sub      = (w_opcode == C_INST_TYPE_R_M) & inst_i[30];

    assign w_i_ok = (w_funct3 == C_F3_SLL) ? (w_funct7 == C_FUNCT7_BASE) :
                    (w_funct3 == C_F3_SR)  ? ((w_funct7 == C_FUNCT7_BASE) || (w_funct7 == C_FUNCT7_ALT)) :
                    1'b1;
    assign w_r_ok = (w_funct7 == C_FUNCT7_BASE) ||
                    ((w_funct7 == C_FUNCT7_ALT) && ((w_funct3 == C_F3_ADD_SUB) || (w_funct3 == C_F3_SR)));

    assign w_is_mul     = (MUL_EN != 0) && (w_opcode == C_INST_TYPE_R_M) &&
                          (w_funct7 == C_FUNCT7_M) && !w_funct3[2];
    assign w_mul_sign_a = (w_funct3 == C_F3_MULH) || (w_funct3 == C_F3_MULHSU);
    assign w_mul_sign_b = (w_funct3 == C_F3_MULH);

    generate
        if (MUL_EN != 0) begin : g_mul
            ex_mul_iter #(
                .XLEN    (XLEN)
            ) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (w_is_mul),
                .sign_a  (w_mul_sign_a),
                .sign_b  (w_mul_sign_b),
                .a       (op1_i),
                .b       (op2_i),
                .busy    (w_mul_busy),
                .done    (w_mul_done),
                .product (w_product)
            );
        end else begin : g_no_mul
            assign w_mul_busy = 1'b0;
            assign w_mul_done = 1'b0;
            assign w_product  = '0;
        end
    endgenerate

    // I-type operands arrive with op2 already holding the sign-extended immediate.
    always_comb begin
        w_alu_res = '0;
        case (w_funct3)
            C_F3_ADD_SUB: w_alu_res = w_sub ? (op1_i - op2_i) : w_sum;
            C_F3_SLL:     w_alu_res = op1_i << w_shamt;
            C_F3_SLT:     w_alu_res = {{(XLEN-1){1'b0}}, w_lt_s};
            C_F3_SLTU:    w_alu_res = {{(XLEN-1){1'b0}}, w_lt_u};
            C_F3_XOR:     w_alu_res = op1_i ^ op2_i;
            C_F3_SR:      w_alu_res = inst_i[30] ? ($signed(op1_i) >>> w_shamt) : (op1_i >> w_shamt);
            C_F3_OR:      w_alu_res = op1_i | op2_i;
            C_F3_AND:     w_alu_res = op1_i & op2_i;
            default:      w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            C_F3_BEQ:  w_taken = (op1_i == op2_i);
            C_F3_BNE:  w_taken = (op1_i != op2_i);
            C_F3_BLT:  w_taken = w_lt_s;
            C_F3_BGE:  w_taken = !w_lt_s;
            C_F3_BLTU: w_taken = w_lt_u;
            C_F3_BGEU: w_taken = !w_lt_u;
            default:   w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_rd_data   = '0;
        w_writes    = 1'b0;
        w_jump_en   = 1'b0;
        w_jump_addr = '0;
        case (w_opcode)
            C_INST_TYPE_I: begin
                if (w_i_ok) begin
                    w_rd_data = w_alu_res;
                    w_writes  = 1'b1;
                end
            end
            C_INST_TYPE_R_M: begin
                if (w_is_mul) begin
                    if (w_mul_done) begin
                        w_writes  = 1'b1;
                        w_rd_data = (w_funct3 == C_F3_MUL) ? w_product[XLEN-1:0]
                                                           : w_product[2*XLEN-1:XLEN];
                    end
                end else if (w_r_ok) begin
                    w_rd_data = w_alu_res;
                    w_writes  = 1'b1;
                end
            end
            C_INST_TYPE_B: begin
                if (w_taken) begin
                    w_jump_en   = 1'b1;
                    w_jump_addr = inst_addr_i + w_imm_b;
                end
            end
            C_INST_TYPE_LUI: begin
                w_rd_data = w_imm_u;
                w_writes  = 1'b1;
            end
            C_INST_TYPE_AUIPC: begin
                w_rd_data = inst_addr_i + w_imm_u;
                w_writes  = 1'b1;
            end
            C_INST_TYPE_JAL: begin
                w_rd_data   = w_pc_plus4;
                w_writes    = 1'b1;
                w_jump_en   = 1'b1;
                w_jump_addr = inst_addr_i + w_imm_j;
            end
            C_INST_TYPE_JALR: begin
                if (w_funct3 == C_F3_JALR) begin
                    w_rd_data   = w_pc_plus4;
                    w_writes    = 1'b1;
                    w_jump_en   = 1'b1;
                    w_jump_addr = w_sum & {{(XLEN-1){1'b1}}, 1'b0};
                end
            end
            default: ;
        endcase
    end

    // Stall from the start cycle through the last shift-add step; release at DONE.
    assign w_hold = (w_is_mul & ~w_mul_busy & ~w_mul_done) | w_mul_busy;

    assign rd_wen_o    = rst & rd_wen_i & w_writes;
    assign rd_addr_o   = rd_wen_o ? rd_addr_i : 5'd0;
    assign rd_data_o   = rst ? w_rd_data : '0;
    assign jump_en_o   = rst & w_jump_en;
    assign jump_addr_o = rst ? w_jump_addr : '0;
    assign hold_flag_o = rst & w_hold;

endmodule
`default_nettype wire
